// File: rtl/common_types.sv
// Shared 6502 core types: bus widths, fetch FSM states and the opcode length table.
package common_types;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;
  typedef logic        mw_t;
  typedef logic [1:0]  ilen_t;

  localparam addr_t RESET_VECTOR = 16'hFFFC;

  typedef enum logic [3:0] {
    V0A,
    V0D,
    V1A,
    V1D,
    OPA,
    OPD,
    B1A,
    B1D,
    B2A,
    B2D,
    HOLD
  } fetch_state_t;

  // Instruction length in bytes; anything not listed is treated as a 1-byte op.
  function automatic ilen_t inst_len(input data_t op);
    ilen_t len;
    case (op)
      8'hA9, 8'hA2, 8'hA5, 8'h85, 8'hD0, 8'hF0: len = 2'd2;
      8'hAD, 8'h8D, 8'h4C, 8'h20:               len = 2'd3;
      default:                                  len = 2'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ilen_decode.sv
// Combinational opcode-to-length decoder.
module ilen_decode
  import common_types::*;
(
  input  data_t opcode,
  output ilen_t ilen
);

  assign ilen = inst_len(opcode);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch initiator: loads PC from the reset vector, then reads opcode plus
// operand bytes and presents each instruction to control over a valid/ready handshake.
module fetch_unit
  import common_types::*;
#(
  parameter addr_t RESET_VEC = RESET_VECTOR
) (
  input  logic  clk,
  input  logic  rst,
  output mw_t   mw,
  output addr_t addr,
  input  data_t mem_rdata,
  input  logic  jmp,
  input  addr_t jmp_addr,
  output logic  inst_valid,
  input  logic  inst_ready,
  output data_t opcode,
  output addr_t operand,
  output ilen_t ilen,
  output addr_t inst_pc
);

  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  data_t        opcode_q, opcode_d;
  data_t        lo_q, lo_d;
  data_t        hi_q, hi_d;
  ilen_t        ilen_q, ilen_d;
  ilen_t        dec_ilen;
  logic         in_vector;

  ilen_decode u_ilen_decode (
    .opcode (mem_rdata),
    .ilen   (dec_ilen)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= V0A;
      pc_q     <= '0;
      opcode_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      ilen_q   <= 2'd1;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      ilen_q   <= ilen_d;
    end
  end

  assign in_vector = (state_q == V0A) || (state_q == V0D) ||
                     (state_q == V1A) || (state_q == V1D);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    ilen_d   = ilen_q;
    addr     = pc_q;

    unique case (state_q)
      V0A: begin
        addr    = RESET_VEC;
        state_d = V0D;
      end
      V0D: begin
        addr    = RESET_VEC;
        lo_d    = mem_rdata;
        state_d = V1A;
      end
      V1A: begin
        addr    = RESET_VEC + 16'd1;
        state_d = V1D;
      end
      V1D: begin
        addr    = RESET_VEC + 16'd1;
        pc_d    = {mem_rdata, lo_q};
        lo_d    = '0;
        state_d = OPA;
      end
      OPA: begin
        addr    = pc_q;
        state_d = OPD;
      end
      OPD: begin
        addr     = pc_q;
        opcode_d = mem_rdata;
        ilen_d   = dec_ilen;
        // Clear operand bytes so shorter instructions never show stale data.
        lo_d     = '0;
        hi_d     = '0;
        state_d  = (dec_ilen == 2'd1) ? HOLD : B1A;
      end
      B1A: begin
        addr    = pc_q + 16'd1;
        state_d = B1D;
      end
      B1D: begin
        addr    = pc_q + 16'd1;
        lo_d    = mem_rdata;
        state_d = (ilen_q == 2'd2) ? HOLD : B2A;
      end
      B2A: begin
        addr    = pc_q + 16'd2;
        state_d = B2D;
      end
      B2D: begin
        addr    = pc_q + 16'd2;
        hi_d    = mem_rdata;
        state_d = HOLD;
      end
      HOLD: begin
        addr = pc_q;
        if (inst_ready) begin
          pc_d    = pc_q + {14'd0, ilen_q};
          state_d = OPA;
        end
      end
      default: state_d = V0A;
    endcase

    // A redirect wins over the handshake and discards any partial fetch.
    if (jmp && !in_vector) begin
      pc_d    = jmp_addr;
      state_d = OPA;
    end
  end

  assign mw         = 1'b0;
  assign inst_valid = (state_q == HOLD);
  assign opcode     = opcode_q;
  assign ilen       = ilen_q;
  assign inst_pc    = pc_q;

  always_comb begin
    unique case (ilen_q)
      2'd3:    operand = {hi_q, lo_q};
      2'd2:    operand = {8'h00, lo_q};
      default: operand = '0;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a synchronous-read memory model.
module tb_fetch_unit;
  import common_types::*;

  logic  clk = 1'b0;
  logic  rst;
  mw_t   mw;
  addr_t addr;
  data_t mem_rdata;
  logic  jmp;
  addr_t jmp_addr;
  logic  inst_valid;
  logic  inst_ready;
  data_t opcode;
  addr_t operand;
  ilen_t ilen;
  addr_t inst_pc;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:65535];

  fetch_unit #(.RESET_VEC(16'hFFFC)) dut (
    .clk        (clk),
    .rst        (rst),
    .mw         (mw),
    .addr       (addr),
    .mem_rdata  (mem_rdata),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .opcode     (opcode),
    .operand    (operand),
    .ilen       (ilen),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    assert (inst_valid === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: inst_valid observed %b expected 1 within 20 cycles", tag, inst_valid);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_inst(input string tag, input logic [7:0] op, input logic [15:0] opr,
                          input logic [1:0] len, input logic [15:0] pc);
    chk({tag, "_opcode"}, {8'h00, opcode}, {8'h00, op});
    chk({tag, "_operand"}, operand, opr);
    chk({tag, "_ilen"}, {14'd0, ilen}, {14'd0, len});
    chk({tag, "_inst_pc"}, inst_pc, pc);
  endtask

  initial begin
    logic [15:0] vec_addrs [6];
    int n;
    vec_addrs = '{16'hFFFC, 16'hFFFC, 16'hFFFD, 16'hFFFD, 16'h1234, 16'h1234};

    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h34;
    mem[16'hFFFD] = 8'h12;
    rst        = 1'b1;
    jmp        = 1'b0;
    jmp_addr   = '0;
    inst_ready = 1'b1;

    // Reset values, then the vector load and a single NOP.
    tick();
    tick();
    chk("rst_addr", addr, 16'hFFFC);
    chk("rst_mw", {15'd0, mw}, 16'd0);
    chk("rst_valid", {15'd0, inst_valid}, 16'd0);
    chk_inst("rst", 8'h00, 16'h0000, 2'd1, 16'h0000);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("vec_addr_c%0d", c + 1), addr, vec_addrs[c]);
      chk($sformatf("vec_valid_c%0d", c + 1), {15'd0, inst_valid}, 16'd0);
      tick();
    end
    chk("c7_valid", {15'd0, inst_valid}, 16'd1);
    chk_inst("c7", 8'hEA, 16'h0000, 2'd1, 16'h1234);
    tick();
    chk("nop_next_addr", addr, 16'h1235);
    chk("nop_next_valid", {15'd0, inst_valid}, 16'd0);

    // Mixed lengths with the consumer always ready.
    mem[16'h1234] = 8'hA9; mem[16'h1235] = 8'h05;
    mem[16'h1236] = 8'hAD; mem[16'h1237] = 8'h00; mem[16'h1238] = 8'h40;
    mem[16'h1239] = 8'hEA;
    do_reset();
    wait_valid("mix_a9", n);
    chk("mix_a9_latency", n[15:0], 16'd8);
    chk_inst("mix_a9", 8'hA9, 16'h0005, 2'd2, 16'h1234);
    tick();
    wait_valid("mix_ad", n);
    chk("mix_ad_latency", n[15:0], 16'd6);
    chk_inst("mix_ad", 8'hAD, 16'h4000, 2'd3, 16'h1236);
    tick();
    wait_valid("mix_ea", n);
    chk("mix_ea_latency", n[15:0], 16'd2);
    chk_inst("mix_ea", 8'hEA, 16'h0000, 2'd1, 16'h1239);

    // Backpressure in HOLD.
    inst_ready = 1'b0;
    do_reset();
    wait_valid("bp", n);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_%0d", c), {15'd0, inst_valid}, 16'd1);
      chk($sformatf("bp_addr_%0d", c), addr, 16'h1234);
      chk_inst($sformatf("bp_%0d", c), 8'hA9, 16'h0005, 2'd2, 16'h1234);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("bp_release_addr", addr, 16'h1236);
    chk("bp_release_valid", {15'd0, inst_valid}, 16'd0);

    // Jump during B1D of the 3-byte AD instruction.
    mem[16'h2000] = 8'hA5; mem[16'h2001] = 8'h10;
    tick();
    tick();
    tick();
    chk("b1d_addr", addr, 16'h1237);
    jmp = 1'b1; jmp_addr = 16'h2000;
    tick();
    jmp = 1'b0;
    chk("jmp_addr", addr, 16'h2000);
    chk("jmp_valid", {15'd0, inst_valid}, 16'd0);
    wait_valid("jmp_inst", n);
    chk("jmp_inst_latency", n[15:0], 16'd4);
    chk_inst("jmp_inst", 8'hA5, 16'h0010, 2'd2, 16'h2000);

    // jmp together with the handshake: the jump target wins.
    mem[16'hFFFF] = 8'hA9; mem[16'h0000] = 8'h77;
    jmp = 1'b1; jmp_addr = 16'hFFFF; inst_ready = 1'b1;
    tick();
    jmp = 1'b0; inst_ready = 1'b0;
    chk("jmp_hs_addr", addr, 16'hFFFF);
    chk("jmp_hs_valid", {15'd0, inst_valid}, 16'd0);

    // Operand read wraps past FFFF.
    wait_valid("wrap", n);
    chk_inst("wrap", 8'hA9, 16'h0077, 2'd2, 16'hFFFF);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("wrap_next_addr", addr, 16'h0001);

    // Reset during OPD, then jmp ignored during the vector load.
    tick();
    chk("opd_addr", addr, 16'h0001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_addr", addr, 16'hFFFC);
    chk("midrst_valid", {15'd0, inst_valid}, 16'd0);
    chk_inst("midrst", 8'h00, 16'h0000, 2'd1, 16'h0000);
    tick();
    chk("midrst_v0d", addr, 16'hFFFC);
    tick();
    chk("midrst_v1a", addr, 16'hFFFD);
    jmp = 1'b1; jmp_addr = 16'h3000;
    tick();
    jmp = 1'b0;
    chk("midrst_v1d", addr, 16'hFFFD);
    tick();
    chk("midrst_opa", addr, 16'h1234);
    wait_valid("midrst_inst", n);
    chk("midrst_inst_latency", n[15:0], 16'd4);
    chk_inst("midrst_inst", 8'hA9, 16'h0005, 2'd2, 16'h1234);
    chk("midrst_mw", {15'd0, mw}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch initiator for the 6502 core: the requesting end of the `cpumemory` read interface. After reset it loads PC from the reset vector, then fetches each opcode and its 0–2 operand bytes. It presents the assembled instruction to `control` over a valid/ready handshake. It sits between `control` and `cpumemory` and replaces the fixed PC path into `memmux`.

## Interface
Parameters:
- `RESET_VEC`, 16'hFFFC: address of the reset-vector low byte; the high byte is at `RESET_VEC+1`.

Ports:
- `clk` input 1: system clock; everything is on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `mw` output `mw_t`: memory write enable; constant 0.
- `addr` output `addr_t`: memory address, combinational from state and PC.
- `mem_rdata` input `data_t`: `cpumemory` data_out; valid the cycle after `addr` is presented.
- `jmp` input 1: load a new PC.
- `jmp_addr` input `addr_t`: target PC, sampled when `jmp`=1.
- `inst_valid` output 1: instruction outputs are valid.
- `inst_ready` input 1: consumer accepts the instruction.
- `opcode` output `data_t`: fetched opcode.
- `operand` output `addr_t`: {hi,lo}; for 2-byte instructions {8'h00,lo}; 0 for 1-byte instructions.
- `ilen` output `ilen_t` (2 bits): instruction length, 1..3.
- `inst_pc` output `addr_t`: address of the opcode.

## Operation
- Every byte read takes two cycles:
  - A-state: `addr` is driven.
  - D-state: `addr` is held and `mem_rdata` is captured.
- States:
  - `V0A`, `V0D`: read the vector low byte.
  - `V1A`, `V1D`: read the vector high byte; PC <= {hi,lo} at the end of `V1D`.
  - `OPA`, `OPD`: read the opcode at PC. `ilen` is decoded from `mem_rdata` in `OPD`.
  - `B1A`, `B1D`: read the byte at PC+1.
  - `B2A`, `B2D`: read the byte at PC+2.
  - `HOLD`: instruction is presented.
- Transitions:
  - `V0A`→`V0D`→`V1A`→`V1D`→`OPA`→`OPD`.
  - `OPD`→`HOLD` if len=1, else →`B1A`.
  - `B1D`→`HOLD` if len=2, else →`B2A`.
  - `B2D`→`HOLD`.
- `HOLD`:
  - `inst_valid`=1; `opcode`, `operand`, `ilen` and `inst_pc` are stable.
  - On `inst_ready`=1: PC <= PC+ilen (mod 2^16), go to `OPA`; `inst_valid`=0 the next cycle.
- `jmp`=1 in any state other than `V*`:
  - PC <= `jmp_addr`, next state `OPA`.
  - Any partial fetch is discarded and `inst_valid`=0 the next cycle.
  - `jmp` has priority over `inst_ready`. A simultaneous `jmp` and handshake in `HOLD` counts as accepted; PC takes `jmp_addr`, not PC+ilen.
- `jmp` is ignored in `V0A`..`V1D`.
- Operand address arithmetic is 16-bit with wrap-around: PC=16'hFFFF reads its operand from 16'h0000.
- Length decode, implemented by function `inst_len`:
  - 8'hA9, 8'hA2, 8'hA5, 8'h85, 8'hD0, 8'hF0: 2.
  - 8'hAD, 8'h8D, 8'h4C, 8'h20: 3.
  - 8'hEA, 8'h60, 8'hE8 and all undefined opcodes: 1.

## Timing
- While `rst`=1 and in the cycle after release: state `V0A`, `addr`=`RESET_VEC`, `mw`=0, `inst_valid`=0; `opcode`, `operand`, `inst_pc` = 0; `ilen`=1; PC=0.
- Reset release to first `OPA`: 4 cycles.
- Cycles from `OPA` entry to the first cycle with `inst_valid`=1: 2 for 1-byte, 4 for 2-byte, 6 for 3-byte instructions.
- No bubble from handshake to the next `OPA`.
- `rst` mid-fetch: the next cycle is `V0A` with all outputs at reset values; no instruction is emitted.
- `inst_valid` never drops without a handshake, `jmp` or `rst`.

## Structure
Additions to the shared `common_types` package:
- `fetch_state_t`: enum of the 11 states.
- `ilen_t`: `logic [1:0]`.
- `RESET_VECTOR` constant.
- `inst_len(data_t)` function.

One combinational sub-module, `ilen_decode`, wraps `inst_len`. The state register, PC and operand capture registers stay in `fetch_unit`.

## Test plan
- Reset vector: memory FFFC=34, FFFD=12, 1234=EA, `inst_ready`=1.
  - `addr` sequence is FFFC,FFFC,FFFD,FFFD,1234,1234.
  - `inst_valid` on cycle 7 with `opcode`=EA, `ilen`=1, `inst_pc`=1234.
- Mixed lengths: 1234: A9 05 AD 00 40 EA.
  - Expect in order: (A9,0005,2,1234), (AD,4000,3,1236), (EA,0000,1,1239).
- Backpressure: `inst_ready`=0 for 5 cycles in `HOLD`.
  - Outputs stable and no `addr` change.
  - One cycle after `inst_ready`=1, `addr`=PC+ilen.
- Jump mid-fetch: `jmp`=1, `jmp_addr`=2000 during `B1D` of a 3-byte instruction.
  - Next cycle `addr`=2000 and no instruction is emitted for the aborted fetch.
  - `jmp` and `inst_ready` together in `HOLD`: next `addr`=`jmp_addr`.
- Wrap: PC=FFFF holding 8'hA9, 0000 holding 8'h77.
  - Expect `operand`=0077, `ilen`=2; next `addr`=0001.
- Reset mid-op: `rst` pulse during `OPD`.
  - Next cycle: state `V0A`, `addr`=FFFC, `inst_valid`=0; the vector sequence repeats.
  - `jmp` asserted during `V1A` has no effect.
